phrase_picker: RTL
==================

PHRASE_PICKER -- requirements
Module: phrase_picker

Interface
REQ-001 Parameter NUM_WORDS, default 8, meaning number of selectable entries (legal 2..256).
REQ-002 Parameter IDX_W, default 3, meaning index width, SHALL equal ceil(log2(NUM_WORDS)).
REQ-003 Parameter HIST_DEPTH, default 1, meaning count of recent picks barred from repeating (legal 1..NUM_WORDS-1).
REQ-004 Parameter MAX_TRIES, default 4, meaning random draws allowed before fallback (legal 1..15).
REQ-005 Parameter SEED, default 16'hACE1, meaning LFSR reset value.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req  input  1  request a new pick; sampled only in IDLE.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; idx is updated on the same cycle.
REQ-011 idx  output  IDX_W  most recent pick; holds between done pulses.

Function
REQ-012 LFSR: 16-bit Fibonacci LFSR; shifts left every cycle in all states; new bit0 = b15^b13^b12^b10.
REQ-013 States SHALL be IDLE, DRAW, FALLBACK, DONE.
REQ-014 IDLE with req=1 -> DRAW; tries cleared to 0.
REQ-015 DRAW: candidate = lfsr[IDX_W-1:0]; accept if candidate < NUM_WORDS and not in valid history -> DONE.
REQ-016 DRAW reject: tries += 1; if tries reaches MAX_TRIES -> FALLBACK with cand = (idx+1) mod NUM_WORDS; else stay in DRAW.
REQ-017 FALLBACK: accept cand if not in valid history -> DONE; else cand = (cand+1) mod NUM_WORDS, one step per cycle.
REQ-018 DONE: done=1, idx=accepted value, history shifts (accepted into slot 0, oldest dropped, slot 0 marked valid); next state IDLE.
REQ-019 Latency: req to done minimum 2 cycles; worst case MAX_TRIES+HIST_DEPTH+2 cycles.
REQ-020 req while busy=1 SHALL be ignored and not queued.
REQ-021 Result SHALL never equal any valid history entry; with HIST_DEPTH=1 consecutive picks always differ.
REQ-022 Empty history slots (valid=0) SHALL never cause a reject.
REQ-023 NUM_WORDS a power of two: out-of-range rejects SHALL never occur.

Reset
REQ-024 rst_n low: state=IDLE, busy=0, done=0, idx=0, tries=0, all history valid bits=0, lfsr=SEED (0 replaced by 16'hACE1).
REQ-025 Reset asserted mid-pick SHALL abort it without a done pulse and without a history update.

Configuration
REQ-026 Macro PHRASE_PICKER_SEED_LOAD_EN defined: adds inputs seed_load (1) and seed (16); seed_load=1 in any state loads lfsr=seed (0 replaced by 16'hACE1) instead of shifting that cycle; FSM unaffected.
REQ-027 Macro undefined: seed ports absent; LFSR seeded only by SEED at reset.

Verification
REQ-028 Reset, SEED default, req pulse -> done within 2..6 cycles, idx in 0..7, busy high from cycle after req until cycle after done.
REQ-029 HIST_DEPTH=1, 1000 back-to-back picks -> no two consecutive idx equal; all 8 values appear.
REQ-030 NUM_WORDS=5, IDX_W=3, HIST_DEPTH=4, 500 picks -> idx always <5; each idx differs from the previous 4.
REQ-031 MAX_TRIES=1, NUM_WORDS=3, HIST_DEPTH=2, seed forcing rejects -> FALLBACK entered, result is the single non-history value, done within 5 cycles.
REQ-032 req held high during busy -> exactly one done per IDLE entry; rst_n low in DRAW -> done never pulses, idx=0, next pick accepts any value.
REQ-033 With PHRASE_PICKER_SEED_LOAD_EN, load seed=16'h1234 twice with identical req timing -> identical idx sequences; seed=0 -> behaves as 16'hACE1.

Source files
------------

// File: rtl/phrase_picker.sv
// ============================================================================
// Module   : phrase_picker
// Purpose  : Picks an index in 0..NUM_WORDS-1 on request, using a 16-bit
//            Fibonacci LFSR. A pick never repeats any of the last HIST_DEPTH
//            picks. After MAX_TRIES rejected random draws, a deterministic
//            walk upward from the previous pick finds a free value.
// Ports    : clk        - clock, all state changes on the rising edge
//            rst_n      - asynchronous active-low reset
//            req        - request a new pick (sampled only when idle)
//            busy       - high whenever a pick is in progress or completing
//            done       - one-cycle pulse, idx updated on the same cycle
//            idx        - most recent pick, held between done pulses
//            seed_load  - (PHRASE_PICKER_SEED_LOAD_EN only) load LFSR this cycle
//            seed       - (PHRASE_PICKER_SEED_LOAD_EN only) value to load
// Options  : define PHRASE_PICKER_SEED_LOAD_EN to add the runtime seed ports.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module phrase_picker #(
    parameter int          NUM_WORDS  = 8,
    parameter int          IDX_W      = 3,
    parameter int          HIST_DEPTH = 1,
    parameter int          MAX_TRIES  = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
`ifdef PHRASE_PICKER_SEED_LOAD_EN
    input  logic             seed_load,
    input  logic [15:0]      seed,
`endif
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_draw     = 2'd1;
    localparam logic [1:0] c_st_fallback = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    // An all-zero LFSR would lock up, so zero is replaced by a fixed seed.
    localparam logic [15:0]      c_alt_seed   = 16'hACE1;
    localparam logic [15:0]      c_reset_seed = (SEED == 16'h0000) ? c_alt_seed : SEED;
    localparam logic [3:0]       c_max_tries  = 4'(MAX_TRIES);
    localparam logic [IDX_W-1:0] c_last       = IDX_W'(NUM_WORDS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_next;
    logic             w_lfsr_fb;
    logic [3:0]       r_tries;
    logic [3:0]       w_tries_inc;
    logic [IDX_W-1:0] r_cand;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_chk;
    logic [IDX_W-1:0] w_acc;
    logic [IDX_W-1:0] r_hist [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] r_hval;
    logic [HIST_DEPTH-1:0] w_hit;
    logic             w_in_range;
    logic             w_in_hist;
    logic             w_take;
    logic             w_reject;
    logic             w_to_fb;
    logic             w_fb_step;

    // Wrapping increment modulo NUM_WORDS (operands are always < NUM_WORDS).
    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] v);
        return (v == c_last) ? '0 : v + IDX_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // LFSR: free-running, shifts left every cycle regardless of state.
    // ------------------------------------------------------------------
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_lfsr_next = {r_lfsr[14:0], w_lfsr_fb};
`ifdef PHRASE_PICKER_SEED_LOAD_EN
        if (seed_load) begin
            w_lfsr_next = (seed == 16'h0000) ? c_alt_seed : seed;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Candidate check: the random draw in DRAW, the walking value in
    // FALLBACK. Only valid history slots can cause a reject.
    // ------------------------------------------------------------------
    assign w_chk       = (r_state == c_st_fallback) ? r_cand : r_lfsr[IDX_W-1:0];
    assign w_in_range  = ({{(32-IDX_W){1'b0}}, w_chk} < NUM_WORDS);
    assign w_tries_inc = r_tries + 4'd1;

    for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_hist_match
        assign w_hit[i] = r_hval[i] && (r_hist[i] == w_chk);
    end

    assign w_in_hist = |w_hit;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_acc        = r_cand;
        w_reject     = 1'b0;
        w_to_fb      = 1'b0;
        w_fb_step    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req) begin
                    w_state_next = c_st_draw;
                end
            end
            c_st_draw: begin
                if (w_in_range && !w_in_hist) begin
                    w_state_next = c_st_done;
                    w_take       = 1'b1;
                    w_acc        = w_chk;
                end else begin
                    w_reject = 1'b1;
                    if (w_tries_inc == c_max_tries) begin
                        w_state_next = c_st_fallback;
                        w_to_fb      = 1'b1;
                    end
                end
            end
            c_st_fallback: begin
                // Terminates within HIST_DEPTH steps since HIST_DEPTH < NUM_WORDS.
                if (!w_in_hist) begin
                    w_state_next = c_st_done;
                    w_take       = 1'b1;
                    w_acc        = r_cand;
                end else begin
                    w_fb_step = 1'b1;
                end
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != c_st_idle);
        done = (r_state == c_st_done);
    end

    assign idx = r_idx;

    // ------------------------------------------------------------------
    // Datapath. idx and history are written on the edge entering DONE so
    // the new idx is visible during the done pulse; a reset before that
    // edge leaves both untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= c_reset_seed;
            r_tries <= '0;
            r_cand  <= '0;
            r_idx   <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (r_state == c_st_idle && req) begin
                r_tries <= '0;
            end else if (w_reject) begin
                r_tries <= w_tries_inc;
            end
            if (w_to_fb) begin
                r_cand <= f_inc(r_idx);
            end else if (w_fb_step) begin
                r_cand <= f_inc(r_cand);
            end
            if (w_take) begin
                r_idx <= w_acc;
            end
        end
    end

    // History shift register: slot 0 holds the newest pick.
    for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_hist_slot
        if (i == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hist[0] <= '0;
                    r_hval[0] <= 1'b0;
                end else if (w_take) begin
                    r_hist[0] <= w_acc;
                    r_hval[0] <= 1'b1;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hist[i] <= '0;
                    r_hval[i] <= 1'b0;
                end else if (w_take) begin
                    r_hist[i] <= r_hist[i-1];
                    r_hval[i] <= r_hval[i-1];
                end
            end
        end
    end

endmodule

`default_nettype wire
